// File: rtl/thread_result_collector.sv
// thread_result_collector
// Collects shaded pixel results from NUM_CORES ray cores and writes them into
// a framebuffer, one pixel per grant. Cores are served round-robin; each
// accepted result is held for one write cycle (or longer while fb_busy is
// high). Results with out-of-range coordinates are dropped and flagged.
//
// Ports
//   clk, reset      : single rising-edge clock, synchronous active-high reset
//   start           : one-cycle pulse, starts (or restarts) a frame
//   core_valid/x/y/color, core_ready : per-core result handshake
//   fb_we, fb_addr, fb_data, fb_busy : framebuffer write port with stall
//   pixel_count     : pixels written in the current frame
//   frame_finished  : every pixel of the frame has been written
//   oor_error       : sticky, an out-of-range result was received
module thread_result_collector #(
    parameter int NUM_CORES = 4,
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120,
    parameter int COORD_W   = 16,
    parameter int ADDR_W    = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_CORES-1:0]         core_valid,
    input  logic [NUM_CORES*COORD_W-1:0] core_x,
    input  logic [NUM_CORES*COORD_W-1:0] core_y,
    input  logic [NUM_CORES*24-1:0]      core_color,
    output logic [NUM_CORES-1:0]         core_ready,
    output logic                         fb_we,
    output logic [ADDR_W-1:0]            fb_addr,
    output logic [23:0]                  fb_data,
    input  logic                         fb_busy,
    output logic [ADDR_W:0]              pixel_count,
    output logic                         frame_finished,
    output logic                         oor_error
);

    localparam int RR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [ADDR_W:0] TOTAL_PIX_C = (ADDR_W+1)'(FB_WIDTH * FB_HEIGHT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_next_s;

    logic [RR_W-1:0]     rr_r;
    logic [RR_W-1:0]     rr_next_s;
    logic [RR_W-1:0]     grant_idx_s;
    logic [RR_W-1:0]     cand_s;
    logic                grant_found_s;
    logic                take_s;

    logic [COORD_W-1:0]  grant_x_s;
    logic [COORD_W-1:0]  grant_y_s;
    logic [23:0]         grant_color_s;
    logic [ADDR_W-1:0]   grant_addr_s;
    logic                grant_oor_s;

    logic [ADDR_W-1:0]   addr_r;
    logic [23:0]         data_r;
    logic                oor_hold_r;
    logic [ADDR_W:0]     pixel_count_r;
    logic [ADDR_W:0]     pixel_count_inc_s;
    logic                oor_error_r;

    logic                grant_s;
    logic                write_done_s;
    logic                oor_drop_s;
    logic                clear_s;

    // Round-robin search: first asserted core_valid at or after rr_r, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        take_s        = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cand_s        = RR_W'((int'(rr_r) + i) % NUM_CORES);
            take_s        = core_valid[cand_s] & ~grant_found_s;
            grant_idx_s   = take_s ? cand_s : grant_idx_s;
            grant_found_s = grant_found_s | core_valid[cand_s];
        end
    end

    // Select the granted core's result and precompute its address and range check.
    always_comb begin
        grant_x_s     = core_x[int'(grant_idx_s)*COORD_W +: COORD_W];
        grant_y_s     = core_y[int'(grant_idx_s)*COORD_W +: COORD_W];
        grant_color_s = core_color[int'(grant_idx_s)*24 +: 24];
        // Only meaningful for in-range coordinates, where it cannot overflow ADDR_W.
        grant_addr_s  = ADDR_W'(32'(grant_y_s) * 32'(FB_WIDTH) + 32'(grant_x_s));
        grant_oor_s   = (32'(grant_x_s) >= 32'(FB_WIDTH)) ||
                        (32'(grant_y_s) >= 32'(FB_HEIGHT));
        rr_next_s     = (grant_idx_s == RR_W'(NUM_CORES - 1)) ? '0 : grant_idx_s + RR_W'(1);
        pixel_count_inc_s = pixel_count_r + (ADDR_W+1)'(1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and handshake decode; start always wins over a grant or write.
    always_comb begin
        state_next_s = state_r;
        core_ready   = '0;
        fb_we        = 1'b0;
        grant_s      = 1'b0;
        write_done_s = 1'b0;
        oor_drop_s   = 1'b0;
        clear_s      = 1'b0;
        if (reset) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        clear_s      = 1'b1;
                        state_next_s = COLLECT;
                    end else begin
                        state_next_s = state_r;
                    end
                end
                COLLECT: begin
                    if (start) begin
                        clear_s      = 1'b1;
                        state_next_s = COLLECT;
                    end else if (grant_found_s) begin
                        grant_s                 = 1'b1;
                        core_ready[grant_idx_s] = 1'b1;
                        state_next_s            = WRITE;
                    end else begin
                        state_next_s = COLLECT;
                    end
                end
                WRITE: begin
                    if (start) begin
                        clear_s      = 1'b1;
                        state_next_s = COLLECT;
                    end else if (oor_hold_r) begin
                        // Out-of-range result: spend the slot without writing.
                        oor_drop_s   = 1'b1;
                        state_next_s = COLLECT;
                    end else begin
                        fb_we = 1'b1;
                        if (!fb_busy) begin
                            write_done_s = 1'b1;
                            state_next_s = (pixel_count_inc_s == TOTAL_PIX_C) ? DONE : COLLECT;
                        end else begin
                            state_next_s = WRITE;
                        end
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // Holding register, round-robin pointer, pixel counter and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_r          <= '0;
            addr_r        <= '0;
            data_r        <= '0;
            oor_hold_r    <= 1'b0;
            pixel_count_r <= '0;
            oor_error_r   <= 1'b0;
        end else if (clear_s) begin
            rr_r          <= '0;
            oor_hold_r    <= 1'b0;
            pixel_count_r <= '0;
            oor_error_r   <= 1'b0;
        end else if (grant_s) begin
            addr_r     <= grant_addr_s;
            data_r     <= grant_color_s;
            oor_hold_r <= grant_oor_s;
            rr_r       <= rr_next_s;
        end else if (write_done_s) begin
            pixel_count_r <= pixel_count_inc_s;
        end else if (oor_drop_s) begin
            oor_error_r <= 1'b1;
            oor_hold_r  <= 1'b0;
        end
    end

    assign fb_addr        = addr_r;
    assign fb_data        = data_r;
    assign pixel_count    = pixel_count_r;
    assign oor_error      = oor_error_r;
    assign frame_finished = (state_r == DONE);

endmodule

// File: tb/tb_thread_result_collector.sv
module tb_thread_result_collector;

    localparam int NC    = 4;
    localparam int FBW   = 160;
    localparam int FBH   = 120;
    localparam int CW    = 16;
    localparam int AW    = 15;
    localparam int TOTAL = FBW * FBH;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [NC-1:0]     core_valid;
    logic [NC*CW-1:0]  core_x;
    logic [NC*CW-1:0]  core_y;
    logic [NC*24-1:0]  core_color;
    logic [NC-1:0]     core_ready;
    logic              fb_we;
    logic [AW-1:0]     fb_addr;
    logic [23:0]       fb_data;
    logic              fb_busy;
    logic [AW:0]       pixel_count;
    logic              frame_finished;
    logic              oor_error;

    always #5 clk = ~clk;

    thread_result_collector #(
        .NUM_CORES(NC), .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .COORD_W(CW), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .core_valid(core_valid), .core_x(core_x), .core_y(core_y), .core_color(core_color),
        .core_ready(core_ready), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .fb_busy(fb_busy), .pixel_count(pixel_count), .frame_finished(frame_finished),
        .oor_error(oor_error)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit timed_out = 1'b0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [23:0]   data;
    } wr_t;
    wr_t sb_q[$];

    typedef struct {
        int            core;
        int            x;
        int            y;
        logic [23:0]   color;
        logic          in_range;
        logic [AW-1:0] exp_addr;
    } vec_t;
    vec_t vecs[9];

    int rr_exp[5] = '{0, 1, 2, 3, 0};
    int g_core[10];
    int g_cyc[10];
    int g_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [23:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        sb_q.push_back(w);
    endtask

    task automatic drive_core(input int core, input int x, input int y, input logic [23:0] color);
        core_x[core*CW +: CW]     = CW'(x);
        core_y[core*CW +: CW]     = CW'(y);
        core_color[core*24 +: 24] = color;
        core_valid[core]          = 1'b1;
    endtask

    // Waits (bounded) for a grant, checks it went to 'core', returns 1ns after the grant edge.
    task automatic wait_grant(input int core);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 16 && !got; c++) begin
            @(negedge clk);
            if (core_ready != '0) begin
                got = 1'b1;
                check("ready_onehot", 32'(core_ready), 32'(1 << core));
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            timed_out = 1'b1;
            $display("FAIL grant_timeout: core %0d got no core_ready within 16 cycles", core);
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Scoreboard: every accepted framebuffer write must match the oldest expected one.
    always @(negedge clk) begin
        if (!reset && fb_we && !fb_busy) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", fb_addr, fb_data);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                check("wr_addr", 32'(fb_addr), 32'(e.addr));
                check("wr_data", 32'(fb_data), 32'(e.data));
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_pc;
        logic exp_oor;
        int idx;

        vecs[0] = '{2,   5,   3, 24'h102030, 1'b1, 15'd485};
        vecs[1] = '{0,   0,   0, 24'hFFFFFF, 1'b1, 15'd0};
        vecs[2] = '{1, 159, 119, 24'h123456, 1'b1, 15'd19199};
        vecs[3] = '{3, 160,   0, 24'h0A0B0C, 1'b0, 15'd0};
        vecs[4] = '{0, 159,   0, 24'h00FF00, 1'b1, 15'd159};
        vecs[5] = '{2,   0, 120, 24'h778899, 1'b0, 15'd0};
        vecs[6] = '{1,   0, 119, 24'h0000FF, 1'b1, 15'd19040};
        vecs[7] = '{3,  17,  42, 24'hC0FFEE, 1'b1, 15'd6737};
        vecs[8] = '{0,  17,  42, 24'hBADA55, 1'b1, 15'd6737};

        reset      = 1'b1;
        start      = 1'b0;
        core_valid = '0;
        core_x     = '0;
        core_y     = '0;
        core_color = '0;
        fb_busy    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_core_ready", 32'(core_ready), 32'd0);
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_fb_data", 32'(fb_data), 32'd0);
        check("rst_pixel_count", 32'(pixel_count), 32'd0);
        check("rst_frame_finished", 32'(frame_finished), 32'd0);
        check("rst_oor_error", 32'(oor_error), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Table-driven single results, including out-of-range and duplicate pixels
        pulse_start();
        exp_pc  = 0;
        exp_oor = 1'b0;
        for (int v = 0; v < 9; v++) begin
            if (vecs[v].in_range) begin
                push_exp(vecs[v].exp_addr, vecs[v].color);
                exp_pc++;
            end else begin
                exp_oor = 1'b1;
            end
            drive_core(vecs[v].core, vecs[v].x, vecs[v].y, vecs[v].color);
            wait_grant(vecs[v].core);
            core_valid = '0;
            @(negedge clk);
            check("vec_fb_we", 32'(fb_we), 32'(vecs[v].in_range));
            @(posedge clk); #1;
            check("vec_pixel_count", 32'(pixel_count), 32'(exp_pc));
            check("vec_oor_error", 32'(oor_error), 32'(exp_oor));
        end

        // Framebuffer stall: write held for 3 busy cycles, counted once
        fb_busy = 1'b1;
        push_exp(15'd1287, 24'hABCDEF);
        drive_core(3, 7, 8, 24'hABCDEF);
        wait_grant(3);
        core_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("busy_fb_we", 32'(fb_we), 32'd1);
            check("busy_fb_addr", 32'(fb_addr), 32'd1287);
            check("busy_fb_data", 32'(fb_data), 32'hABCDEF);
            check("busy_pixel_count", 32'(pixel_count), 32'(exp_pc));
            @(posedge clk); #1;
        end
        fb_busy = 1'b0;
        @(negedge clk);
        check("busy_release_fb_we", 32'(fb_we), 32'd1);
        @(posedge clk); #1;
        check("busy_pixel_count_inc", 32'(pixel_count), 32'(exp_pc + 1));
        @(posedge clk); #1;
        check("busy_pixel_count_once", 32'(pixel_count), 32'(exp_pc + 1));

        // Round-robin with all cores valid; start mid-frame aborts without a grant
        for (int i = 0; i < NC; i++) begin
            drive_core(i, i + 1, 10, 24'hA00000 + 24'(i));
        end
        for (int k = 0; k < 5; k++) begin
            push_exp(AW'(1601 + rr_exp[k]), 24'hA00000 + 24'(rr_exp[k]));
        end
        start = 1'b1;
        @(negedge clk);
        check("abort_no_ready", 32'(core_ready), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        g_n = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (core_ready != '0) begin
                check("rr_onehot", 32'($countones(core_ready)), 32'd1);
                idx = 0;
                for (int b = 0; b < NC; b++) begin
                    if (core_ready[b]) idx = b;
                end
                if (g_n < 10) begin
                    g_core[g_n] = idx;
                    g_cyc[g_n]  = cyc;
                end
                g_n++;
            end
        end
        @(posedge clk); #1;
        core_valid = '0;
        check("rr_grant_count", 32'(g_n), 32'd5);
        for (int k = 0; k < 5 && k < g_n; k++) begin
            check("rr_grant_core", 32'(g_core[k]), 32'(rr_exp[k]));
            check("rr_grant_cycle", 32'(g_cyc[k]), 32'(2 * k));
        end
        repeat (2) @(posedge clk); #1;

        // Full frame from a single core
        pulse_start();
        check("frame_start_pixel_count", 32'(pixel_count), 32'd0);
        for (int p = 0; p < TOTAL && !timed_out; p++) begin
            push_exp(AW'(p), 24'(p) ^ 24'h5A5A5A);
            drive_core(0, p % FBW, p / FBW, 24'(p) ^ 24'h5A5A5A);
            wait_grant(0);
        end
        @(negedge clk);
        @(negedge clk);
        check("done_frame_finished", 32'(frame_finished), 32'd1);
        check("done_pixel_count", 32'(pixel_count), 32'(TOTAL));
        check("done_core_ready", 32'(core_ready), 32'd0);
        check("done_fb_we", 32'(fb_we), 32'd0);
        @(negedge clk);
        check("done_core_ready_held", 32'(core_ready), 32'd0);
        check("done_frame_finished_held", 32'(frame_finished), 32'd1);
        @(posedge clk); #1;
        core_valid = '0;
        pulse_start();
        @(negedge clk);
        check("restart_frame_finished", 32'(frame_finished), 32'd0);
        check("restart_pixel_count", 32'(pixel_count), 32'd0);

        // Reset during a stalled write drops it
        @(posedge clk); #1;
        fb_busy = 1'b1;
        drive_core(1, 1, 1, 24'h55AA55);
        wait_grant(1);
        core_valid = '0;
        @(negedge clk);
        check("pre_reset_fb_we", 32'(fb_we), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("wrst_fb_we", 32'(fb_we), 32'd0);
        check("wrst_core_ready", 32'(core_ready), 32'd0);
        check("wrst_fb_addr", 32'(fb_addr), 32'd0);
        check("wrst_fb_data", 32'(fb_data), 32'd0);
        check("wrst_pixel_count", 32'(pixel_count), 32'd0);
        check("wrst_frame_finished", 32'(frame_finished), 32'd0);
        check("wrst_oor_error", 32'(oor_error), 32'd0);
        @(posedge clk); #1;
        reset   = 1'b0;
        fb_busy = 1'b0;
        repeat (2) @(posedge clk); #1;

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/thread_result_collector.md
THREAD_RESULT_COLLECTOR -- requirements
Module: thread_result_collector

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, meaning number of ray cores returning results.
REQ-002 SHALL have parameter FB_WIDTH, default 160, meaning framebuffer width in pixels.
REQ-003 SHALL have parameter FB_HEIGHT, default 120, meaning framebuffer height in pixels.
REQ-004 SHALL have parameter COORD_W, default 16, meaning screen-coordinate width.
REQ-005 SHALL have parameter ADDR_W, default 15, meaning framebuffer address width (>= clog2(FB_WIDTH*FB_HEIGHT)).
REQ-006 clk  in  1  single clock; all logic on the rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  one-cycle pulse; begins a new frame.
REQ-009 core_valid  in  NUM_CORES  per-core result valid.
REQ-010 core_x  in  NUM_CORES*COORD_W  per-core pixel x.
REQ-011 core_y  in  NUM_CORES*COORD_W  per-core pixel y.
REQ-012 core_color  in  NUM_CORES*24  per-core RGB8 color, R in [23:16].
REQ-013 core_ready  out  NUM_CORES  per-core accept strobe.
REQ-014 fb_we  out  1  framebuffer write request.
REQ-015 fb_addr  out  ADDR_W  write address, y*FB_WIDTH + x.
REQ-016 fb_data  out  24  write color.
REQ-017 fb_busy  in  1  framebuffer stall; write not taken while high.
REQ-018 pixel_count  out  ADDR_W+1  pixels written this frame.
REQ-019 frame_finished  out  1  all FB_WIDTH*FB_HEIGHT pixels written.
REQ-020 oor_error  out  1  sticky; a result with out-of-range coordinates was received.

Function
REQ-021 SHALL implement states IDLE, COLLECT, WRITE, DONE.
REQ-022 IDLE: outputs quiescent; start -> COLLECT, clearing pixel_count, frame_finished, oor_error, rr pointer.
REQ-023 COLLECT: round-robin grant among asserted core_valid, searching cyclically from pointer rr (reset 0); grant g = first valid index >= rr, wrapping.
REQ-024 In the grant cycle, core_ready[g] SHALL pulse high for exactly one cycle, combinationally with core_valid[g]; all other core_ready bits low.
REQ-025 On grant: latch x, y, color of core g into holding register; rr <= (g+1) mod NUM_CORES; go to WRITE.
REQ-026 Cores SHALL hold valid and data stable until ready; a core not granted SHALL NOT be acknowledged.
REQ-027 If latched x >= FB_WIDTH or y >= FB_HEIGHT: no fb write, oor_error <= 1, pixel_count unchanged, return to COLLECT next cycle.
REQ-028 WRITE: fb_we = 1, fb_addr and fb_data from holding register, stable while fb_busy = 1.
REQ-029 Write completes on a cycle with fb_we = 1 and fb_busy = 0; then pixel_count increments by 1.
REQ-030 After completion: pixel_count (new) == FB_WIDTH*FB_HEIGHT -> DONE, else -> COLLECT.
REQ-031 Throughput: at most one pixel per 2 cycles (grant cycle + write cycle) with fb_busy low.
REQ-032 Address arithmetic: fb_addr = y*FB_WIDTH + x computed in ADDR_W bits from in-range coordinates; no truncation for in-range values.
REQ-033 DONE: frame_finished = 1 held; core_ready all 0; fb_we = 0; start -> COLLECT with clears per REQ-022.
REQ-034 start in COLLECT or WRITE (mid-frame): abort, discard holding register without writing, clear per REQ-022, enter COLLECT next cycle; no core_ready in that cycle.
REQ-035 Duplicate pixel coordinates SHALL be written and counted each time; no de-duplication.
REQ-036 core_ready SHALL be 0 in IDLE, WRITE and DONE.

Reset
REQ-037 reset has priority over start and all other inputs.
REQ-038 On reset: state IDLE, rr = 0, pixel_count = 0, frame_finished = 0, oor_error = 0, fb_we = 0, core_ready = 0, fb_addr = 0, fb_data = 0.
REQ-039 reset during WRITE SHALL drop the pending write (fb_we = 0 next cycle).

Verification
REQ-040 start, core 2 valid x=5 y=3 color 0x102030 -> core_ready[2] pulse, next cycle fb_we=1 fb_addr=485 fb_data=0x102030, pixel_count=1.
REQ-041 All 4 cores valid continuously from rr=0 -> grants in order 0,1,2,3,0; each core_ready one cycle, 2 cycles apart.
REQ-042 WRITE with fb_busy high 3 cycles -> fb_we held, addr/data stable 4 cycles, pixel_count increments once.
REQ-043 Result x=160 y=0 -> no fb_we, oor_error=1 sticky, pixel_count unchanged.
REQ-044 19200 in-range results -> frame_finished=1 after last write, core_ready stays 0; start -> frame_finished=0, pixel_count=0.
REQ-045 reset asserted during WRITE with fb_busy high -> next cycle fb_we=0, all outputs at REQ-038 values.
